// File: rtl/cms_word_packer.sv
// cms_word_packer: byte-to-word packer with keep mask and word FIFO; optional inter-byte timeout under CMS_PACK_TIMEOUT_EN
module cms_word_packer #(
  parameter int BYTES_PER_WORD = 4,
  parameter int FIFO_DEPTH     = 16,
  parameter int CNT_W          = 8,
  parameter int TIMEOUT_CYC    = 1024
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            start_i,
  input  logic [CNT_W-1:0]                byte_numb_i,
  input  logic                            order_i,
  input  logic [7:0]                      data_i,
  input  logic                            data_valid_i,
  output logic                            busy_o,
  output logic                            package_done_o,
  output logic                            error_o,
  input  logic                            rd_en_i,
  output logic [8*BYTES_PER_WORD-1:0]     data_fifo_o,
  output logic [BYTES_PER_WORD-1:0]       keep_o,
  output logic                            empty_o,
  output logic                            full_o,
  output logic [$clog2(FIFO_DEPTH):0]     data_count_o
);
  localparam int W  = 8*BYTES_PER_WORD;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = BYTES_PER_WORD > 1 ? $clog2(BYTES_PER_WORD) : 1;
  localparam logic [AW:0]   FULL_CNT = (AW+1)'(FIFO_DEPTH);
  localparam logic [LW-1:0] TOP_LANE = LW'(BYTES_PER_WORD-1);

  if (BYTES_PER_WORD < 1 || BYTES_PER_WORD > 8) begin : g_bpw_chk
    $error("BYTES_PER_WORD must be 1..8");
  end
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH-1)) != 0) begin : g_depth_chk
    $error("FIFO_DEPTH must be a power of 2, at least 2");
  end
  if (TIMEOUT_CYC < 1) begin : g_to_chk
    $error("TIMEOUT_CYC must be positive");
  end

  typedef enum logic [1:0] {IDLE, RUN, DONE, ERROR} state_t;

  state_t                state_q, state_d;
  logic [CNT_W-1:0]      remaining_q, remaining_d;
  logic                  order_q, order_d;
  logic [LW-1:0]         lane_cnt_q, lane_cnt_d;
  logic [W-1:0]          word_q, word_d;
  logic [BYTES_PER_WORD-1:0] keep_q, keep_d;
  logic                  done_q, done_d;
  logic [AW-1:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]           count_q, count_d;
  logic [W-1:0]          rd_data_q, rd_data_d;
  logic [BYTES_PER_WORD-1:0] rd_keep_q, rd_keep_d;
  logic [W-1:0]          mem_data [FIFO_DEPTH];
  logic [BYTES_PER_WORD-1:0] mem_keep [FIFO_DEPTH];
  logic                  accept, last, complete, push, rd_ok, wr_ok, overflow, timeout;
  logic [LW-1:0]         lane_idx;
  logic [W-1:0]          word_new;
  logic [BYTES_PER_WORD-1:0] keep_new;

  assign accept   = state_q == RUN && data_valid_i;
  assign last     = remaining_q == CNT_W'(1);
  assign complete = lane_cnt_q == TOP_LANE || last;
  assign push     = accept && complete;
  assign full_o   = count_q == FULL_CNT;
  assign empty_o  = count_q == '0;
  assign rd_ok    = rd_en_i && !empty_o;
  assign overflow = push && full_o && !rd_en_i;
  assign wr_ok    = push && !overflow;
  assign lane_idx = order_q ? TOP_LANE - lane_cnt_q : lane_cnt_q;

`ifdef CMS_PACK_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC+1);
  logic [TW-1:0] to_cnt_q, to_cnt_d;
  assign timeout = state_q == RUN && !accept && to_cnt_q == TW'(TIMEOUT_CYC-1);
  // idle-cycle counter, held at zero outside RUN and restarted by each accepted byte
  always_comb to_cnt_d = (state_q != RUN || accept) ? '0 : to_cnt_q + TW'(1);
  // timeout counter register
  always_ff @(posedge clk or posedge rst)
    if (rst) to_cnt_q <= '0;
    else     to_cnt_q <= to_cnt_d;
`else
  assign timeout = 1'b0;
`endif

  // merge the incoming byte into its lane of the assembly word
  always_comb begin
    word_new = word_q;
    keep_new = keep_q;
    for (int i = 0; i < BYTES_PER_WORD; i++)
      if (LW'(i) == lane_idx) begin
        word_new[8*i +: 8] = data_i;
        keep_new[i]        = 1'b1;
      end
  end

  // control FSM next state and assembly register updates
  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    order_d     = order_q;
    lane_cnt_d  = lane_cnt_q;
    word_d      = word_q;
    keep_d      = keep_q;
    if (state_q == IDLE && start_i) begin
      state_d     = byte_numb_i == '0 ? DONE : RUN;
      remaining_d = byte_numb_i;
      order_d     = order_i;
      lane_cnt_d  = '0;
      word_d      = '0;
      keep_d      = '0;
    end else if (state_q == RUN && accept) begin
      remaining_d = remaining_q - CNT_W'(1);
      lane_cnt_d  = complete ? '0 : lane_cnt_q + LW'(1);
      word_d      = complete ? '0 : word_new;
      keep_d      = complete ? '0 : keep_new;
      state_d     = overflow ? ERROR : last ? DONE : RUN;
    end else if (state_q == RUN && timeout) begin
      state_d    = ERROR;
      lane_cnt_d = '0;
      word_d     = '0;
      keep_d     = '0;
    end else if (state_q == DONE) begin
      state_d = IDLE;
    end else if (state_q == ERROR && start_i) begin
      state_d = IDLE;
    end
  end

  // FIFO pointers, occupancy and registered read port
  always_comb begin
    wr_ptr_d  = wr_ok ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d  = rd_ok ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d   = count_q + {{AW{1'b0}}, wr_ok} - {{AW{1'b0}}, rd_ok};
    rd_data_d = rd_ok ? mem_data[rd_ptr_q] : rd_data_q;
    rd_keep_d = rd_ok ? mem_keep[rd_ptr_q] : rd_keep_q;
    done_d    = state_q == DONE;
  end

  // word storage; contents need no reset since occupancy gates every read
  always_ff @(posedge clk)
    if (wr_ok) begin
      mem_data[wr_ptr_q] <= word_new;
      mem_keep[wr_ptr_q] <= keep_new;
    end

  // state and datapath registers
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q     <= IDLE;
      remaining_q <= '0;
      order_q     <= 1'b0;
      lane_cnt_q  <= '0;
      word_q      <= '0;
      keep_q      <= '0;
      done_q      <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      rd_data_q   <= '0;
      rd_keep_q   <= '0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      order_q     <= order_d;
      lane_cnt_q  <= lane_cnt_d;
      word_q      <= word_d;
      keep_q      <= keep_d;
      done_q      <= done_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      rd_data_q   <= rd_data_d;
      rd_keep_q   <= rd_keep_d;
    end

  assign busy_o         = state_q == RUN;
  assign error_o        = state_q == ERROR;
  assign package_done_o = done_q;
  assign data_fifo_o    = rd_data_q;
  assign keep_o         = rd_keep_q;
  assign data_count_o   = count_q;
endmodule

// File: tb/tb_cms_word_packer.sv
// tb_cms_word_packer: scoreboard bench for cms_word_packer (4-byte words, 4-deep FIFO, 16-cycle timeout)
module tb_cms_word_packer;
  localparam int BPW   = 4;
  localparam int W     = 8*BPW;
  localparam int DEPTH = 4;

  logic clk = 1'b0, rst = 1'b1;
  logic start_i = 1'b0, order_i = 1'b0, data_valid_i = 1'b0, rd_en_i = 1'b0;
  logic [7:0] byte_numb_i = '0, data_i = '0;
  logic busy_o, package_done_o, error_o, empty_o, full_o;
  logic [W-1:0] data_fifo_o;
  logic [BPW-1:0] keep_o;
  logic [$clog2(DEPTH):0] data_count_o;

  logic [BPW+W-1:0] sb[$];
  logic [W-1:0] m_word, last_word;
  logic [BPW-1:0] m_keep;
  logic m_ord;
  int n_cmp = 0, n_bad = 0;
  bit ovf;

  cms_word_packer #(.BYTES_PER_WORD(BPW), .FIFO_DEPTH(DEPTH), .CNT_W(8), .TIMEOUT_CYC(16)) dut (
    .clk(clk), .rst(rst), .start_i(start_i), .byte_numb_i(byte_numb_i), .order_i(order_i),
    .data_i(data_i), .data_valid_i(data_valid_i), .busy_o(busy_o), .package_done_o(package_done_o),
    .error_o(error_o), .rd_en_i(rd_en_i), .data_fifo_o(data_fifo_o), .keep_o(keep_o),
    .empty_o(empty_o), .full_o(full_o), .data_count_o(data_count_o));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic start_pkt(input int n, input bit ord);
    start_i = 1'b1; byte_numb_i = 8'(n); order_i = ord;
    m_ord = ord; m_word = '0; m_keep = '0;
    tick;
    start_i = 1'b0;
    chk("start busy", busy_o, n > 0);
  endtask

  task automatic send(input int first, input int cnt, input int total, input logic [7:0] base,
                      input logic [7:0] step, input int rd_at, output bit of);
    logic [BPW+W-1:0] exp_rd;
    bit have_rd;
    of = 0;
    for (int j = first; j < first + cnt; j++) begin
      logic [7:0] b;
      int lane, pos;
      b = base + step * 8'(j);
      lane = j % BPW;
      pos = m_ord ? BPW - 1 - lane : lane;
      m_word[8*pos +: 8] = b;
      m_keep[pos] = 1'b1;
      data_i = b; data_valid_i = 1'b1; rd_en_i = (j == rd_at);
      have_rd = (j == rd_at);
      if (have_rd) exp_rd = sb.pop_front();
      if (lane == BPW - 1 || j == total - 1) begin
        if (sb.size() == DEPTH) of = 1;
        else sb.push_back({m_keep, m_word});
        m_word = '0; m_keep = '0;
      end
      tick;
      rd_en_i = 1'b0;
      if (have_rd) begin
        chk("rw word", data_fifo_o, exp_rd[W-1:0]);
        chk("rw keep", keep_o, exp_rd[W +: BPW]);
        last_word = exp_rd[W-1:0];
      end
      if (of) break;
    end
    data_valid_i = 1'b0;
  endtask

  task automatic chk_done;
    chk("done early", package_done_o, 0);
    chk("done busy", busy_o, 0);
    tick;
    chk("done pulse", package_done_o, 1);
    tick;
    chk("done clear", package_done_o, 0);
  endtask

  task automatic drain(input int k);
    for (int i = 0; i < k; i++) begin
      logic [BPW+W-1:0] e;
      e = sb.pop_front();
      rd_en_i = 1'b1;
      tick;
      rd_en_i = 1'b0;
      chk("rd word", data_fifo_o, e[W-1:0]);
      chk("rd keep", keep_o, e[W +: BPW]);
      chk("rd count", data_count_o, sb.size());
      last_word = e[W-1:0];
    end
  endtask

  task automatic rd_const(input logic [W-1:0] w, input logic [BPW-1:0] k);
    void'(sb.pop_front());
    rd_en_i = 1'b1;
    tick;
    rd_en_i = 1'b0;
    chk("const word", data_fifo_o, w);
    chk("const keep", keep_o, k);
    last_word = w;
  endtask

  initial begin
    last_word = '0;
    repeat (3) tick;
    chk("rst empty", empty_o, 1);
    chk("rst full", full_o, 0);
    chk("rst busy", busy_o, 0);
    chk("rst done", package_done_o, 0);
    chk("rst err", error_o, 0);
    chk("rst data", data_fifo_o, 0);
    chk("rst keep", keep_o, 0);
    chk("rst count", data_count_o, 0);
    rst = 1'b0;
    tick;

    start_pkt(4, 0);
    send(0, 4, 4, 8'h11, 8'h11, -1, ovf);
    chk("t1 count", data_count_o, 1);
    chk_done;
    rd_const(32'h44332211, 4'b1111);

    start_pkt(6, 1);
    send(0, 6, 6, 8'h01, 8'h01, -1, ovf);
    chk("t2 count", data_count_o, 2);
    chk_done;
    rd_const(32'h01020304, 4'b1111);
    rd_const(32'h05060000, 4'b1100);

    start_pkt(0, 0);
    chk_done;
    chk("zero empty", empty_o, 1);

    start_pkt(20, 1);
    send(0, 20, 20, 8'h40, 8'h03, -1, ovf);
    chk("ovf model", ovf, 1);
    chk("ovf err", error_o, 1);
    chk("ovf full", full_o, 1);
    chk("ovf count", data_count_o, DEPTH);
    chk("ovf busy", busy_o, 0);
    tick;
    chk("ovf no done", package_done_o, 0);
    chk("ovf sticky", error_o, 1);
    start_i = 1'b1;
    tick;
    start_i = 1'b0;
    chk("err clear", error_o, 0);
    chk("err idle", busy_o, 0);
    drain(DEPTH);

    start_pkt(16, 0);
    send(0, 16, 16, 8'h80, 8'h01, -1, ovf);
    chk_done;
    chk("fill full", full_o, 1);
    start_pkt(4, 1);
    send(0, 4, 4, 8'hC0, 8'h05, 3, ovf);
    chk("rw err", error_o, 0);
    chk("rw count", data_count_o, DEPTH);
    chk("rw full", full_o, 1);
    chk_done;
    drain(DEPTH);

    start_pkt(4, 0);
    send(0, 2, 4, 8'hA0, 8'h01, -1, ovf);
`ifdef CMS_PACK_TIMEOUT_EN
    repeat (15) tick;
    chk("to pre busy", busy_o, 1);
    chk("to pre err", error_o, 0);
    tick;
    chk("to err", error_o, 1);
    chk("to count", data_count_o, 0);
    start_i = 1'b1;
    tick;
    start_i = 1'b0;
    chk("to clear", error_o, 0);
`else
    repeat (40) tick;
    chk("wait busy", busy_o, 1);
    chk("wait err", error_o, 0);
    chk("wait count", data_count_o, 0);
    send(2, 2, 4, 8'hA0, 8'h01, -1, ovf);
    chk_done;
    drain(1);
`endif

    rd_en_i = 1'b1;
    tick;
    rd_en_i = 1'b0;
    chk("empty rd data", data_fifo_o, last_word);
    chk("empty rd flag", empty_o, 1);
    chk("empty rd count", data_count_o, 0);

    start_pkt(8, 0);
    send(0, 5, 8, 8'h30, 8'h01, -1, ovf);
    chk("pre rst count", data_count_o, 1);
    rst = 1'b1;
    #2;
    chk("mid rst count", data_count_o, 0);
    chk("mid rst empty", empty_o, 1);
    chk("mid rst busy", busy_o, 0);
    chk("mid rst data", data_fifo_o, 0);
    sb.delete();
    tick;
    rst = 1'b0;
    tick;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/cms_word_packer.md
# cms_word_packer

Parametrised byte-to-word packer between the CMS AD-card byte capture path and the downstream word FIFO reader. It accepts a command-defined number of bytes and packs them into words of `BYTES_PER_WORD` bytes, with selectable byte order. Each word carries a per-lane keep mask, so a partial final word is marked. Words are buffered in an internal FIFO of `FIFO_DEPTH` words. Overflow and byte-starvation errors are reported instead of hanging.

## Interface
- `BYTES_PER_WORD`, 4: bytes per output word, 1..8. `W = 8*BYTES_PER_WORD`.
- `FIFO_DEPTH`, 16: word FIFO depth. Must be a power of 2, at least 2.
- `CNT_W`, 8: width of the byte count.
- `TIMEOUT_CYC`, 1024: inter-byte timeout in cycles. Used only with `CMS_PACK_TIMEOUT_EN`.

Ports:
- `clk`  in  1  single clock; all logic on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `start_i`  in  1  start a package; sampled only in IDLE or ERROR.
- `byte_numb_i`  in  CNT_W  number of bytes in the package; latched on start.
- `order_i`  in  1  0 = first byte in lane 0 (bits [7:0]); 1 = first byte in the top lane. Latched on start.
- `data_i`  in  8  capture byte.
- `data_valid_i`  in  1  `data_i` valid this cycle; no backpressure.
- `busy_o`  out  1  high in RUN.
- `package_done_o`  out  1  one-cycle pulse at package end.
- `error_o`  out  1  sticky error flag.
- `rd_en_i`  in  1  FIFO read request.
- `data_fifo_o`  out  W  read word.
- `keep_o`  out  BYTES_PER_WORD  valid lanes of `data_fifo_o`.
- `empty_o`, `full_o`  out  1  FIFO flags.
- `data_count_o`  out  clog2(FIFO_DEPTH)+1  words stored.

## Operation
States: IDLE, RUN, DONE, ERROR.

- **IDLE**
  - `start_i`=1 with `byte_numb_i`=0 -> DONE, no FIFO write.
  - `start_i`=1 with `byte_numb_i`>0 -> latch count and order, clear lane counter and assembly register -> RUN.
- **RUN**
  - Each cycle with `data_valid_i`=1 writes `data_i` into lane `lane_cnt` (order 0) or lane `BYTES_PER_WORD-1-lane_cnt` (order 1). Then `lane_cnt`++ and `remaining`--.
  - The word completes when all lanes are filled or the last byte of the package arrives.
  - On completion, the word (including the byte just accepted) and its keep mask are pushed into the FIFO at that same edge. Unfilled lanes are 0 with keep=0.
  - The assembly register and `lane_cnt` clear after each push.
  - Accepting the last byte -> DONE.
- **DONE**: `package_done_o`=1 for exactly one cycle, then IDLE.
- **Overflow**
  - A push while `full_o`=1 with no same-cycle `rd_en_i` drops the word and goes to ERROR.
  - A push and a read in the same cycle while full both succeed; the count stays unchanged.
- **ERROR**
  - `error_o`=1; `package_done_o` is never asserted.
  - The partial word is discarded; FIFO contents remain readable.
  - `start_i`=1 clears `error_o` and returns to IDLE. A new `start_i` is then needed to begin a package.
- `data_valid_i` outside RUN is ignored.
- `start_i` in RUN or DONE is ignored.
- **FIFO reads**
  - `rd_en_i` on an empty FIFO is ignored; pointers and data are unchanged.
  - Pointers wrap modulo `FIFO_DEPTH`.
  - `full_o` = (count == `FIFO_DEPTH`); `empty_o` = (count == 0).

## Timing
- Reset values: state IDLE, all FIFO pointers and counts 0, `empty_o`=1, `full_o`=0, `busy_o`=0, `package_done_o`=0, `error_o`=0, `data_fifo_o`=0, `keep_o`=0.
- Reset mid-package empties the FIFO and discards the partial word.
- Push latency: the word is in the FIFO at the edge that samples its last byte. `data_count_o` and `empty_o` update at that same edge.
- Read latency: `data_fifo_o` and `keep_o` are registered and valid the cycle after `rd_en_i`. They hold their value until the next read.
- `package_done_o` rises on the edge after the last byte is sampled.
- With back-to-back `data_valid_i`, sustained throughput is one byte per cycle with no bubbles at word boundaries.

## Configuration
- `CMS_PACK_TIMEOUT_EN` defined:
  - In RUN, a cycle counter resets on every accepted byte and on entry to RUN.
  - When it reaches `TIMEOUT_CYC` with no byte accepted -> ERROR, partial word discarded.
- Not defined: no counter is built, RUN waits indefinitely, and `TIMEOUT_CYC` is unused.

## Test plan
- **Aligned package, order 0**: defaults; start with count 4, bytes 0x11,0x22,0x33,0x44 back-to-back -> one word 0x44332211, keep 4'b1111; `package_done_o` one pulse; `data_count_o` 1.
- **Partial final word, order 1**: count 6, bytes 0x01..0x06 -> words 0x01020304 (keep 1111) then 0x05060000 (keep 1100).
- **Zero count**: count 0 -> `package_done_o` pulses 2 cycles after start, FIFO stays empty, `busy_o` never high.
- **Overflow**: `FIFO_DEPTH`=2, count 12, no reads -> 2 words stored, third word dropped, `error_o`=1, no done pulse. Both stored words still read back correctly. `start_i` clears `error_o`.
- **Full with simultaneous read/write**: `FIFO_DEPTH`=2, FIFO full, `rd_en_i` on the cycle the third word completes -> no error, count stays 2, read order preserved.
- **Timeout** (`CMS_PACK_TIMEOUT_EN`, `TIMEOUT_CYC`=16): count 4, send 2 bytes then idle -> ERROR exactly 16 cycles after the last byte, nothing pushed. Without the macro, the same stimulus stays in RUN indefinitely.
